// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM sequencing FETCH/DECODE/EXECUTE/MEM/WB, stalling on MemReady.
// Define MULTICYCLE_JUMP_EN to decode J/JAL into the JUMP state; otherwise they are illegal.
module multicycle_control #(
  parameter int ALUOP_WIDTH = 3,
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             OP,
  input  logic                   Zero,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic [1:0]             RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic [1:0]             PCSource,
  output logic                   IllegalOp,
  output logic [STATE_WIDTH-1:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXE   = 4'd6,  S_RWB   = 4'd7,
    S_BRANCH = 4'd8,  S_IEXE   = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11
  } state_t;

  typedef struct packed {
    logic       fetch;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       jump;
    logic       branch;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
`endif

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       illegal_q, illegal_d;

  // Moore control word of a state; op selects the I-type ALU function and JAL link write.
  function automatic ctrl_t decode_ctrl(state_t s, logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'd1; end
      S_DECODE: c.alu_src_b = 2'd3;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_REXE:   begin c.alu_src_a = 1'b1; c.alu_op = 3'b010; end
      S_RWB:    begin c.reg_dst = 2'd1; c.reg_write = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_source = 2'd1; c.branch = 1'b1;
      end
      S_IEXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        case (op)
          OP_ADDI: c.alu_op = 3'b100;
          OP_ANDI: c.alu_op = 3'b110;
          OP_ORI:  c.alu_op = 3'b101;
          default: c.alu_op = 3'b111;
        endcase
      end
      S_IWB:    c.reg_write = 1'b1;
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        c.jump = 1'b1;
        c.pc_source = 2'd2;
        if (op == OP_JAL) begin
          c.reg_write = 1'b1;
          c.reg_dst = 2'd2;
        end
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d   = S_FETCH;
    op_d      = op_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        op_d = OP;
        case (OP)
          OP_R:                             state_d = S_REXE;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IEXE;
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
          OP_J, OP_JAL:                     state_d = S_JUMP;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
      S_REXE:   state_d = S_RWB;
      S_IEXE:   state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
    ctrl_d = decode_ctrl(state_d, op_d);
  end

  // Control word resets to the FETCH word so FETCH outputs appear the cycle reset drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      ctrl_q    <= decode_ctrl(S_FETCH, 6'h00);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  logic [ALUOP_WIDTH-1:0] aluop_ext;
  logic [STATE_WIDTH-1:0] state_ext;
  always_comb begin
    aluop_ext      = '0;
    aluop_ext[2:0] = ctrl_q.alu_op;
    state_ext      = '0;
    state_ext[3:0] = state_q;
  end

  assign PCWrite     = ~reset & ((ctrl_q.fetch & MemReady) | ctrl_q.jump);
  assign PCWriteCond = ~reset & ctrl_q.branch & ((op_q == OP_BEQ) ? Zero : ~Zero);
  assign IRWrite     = ~reset & ctrl_q.fetch & MemReady;
  assign IorD        = ~reset & ctrl_q.iord;
  assign MemRead     = ~reset & ctrl_q.mem_read;
  assign MemWrite    = ~reset & ctrl_q.mem_write;
  assign MemtoReg    = ~reset & ctrl_q.mem_to_reg;
  assign RegDst      = reset ? 2'd0 : ctrl_q.reg_dst;
  assign RegWrite    = ~reset & ctrl_q.reg_write;
  assign ALUSrcA     = ~reset & ctrl_q.alu_src_a;
  assign ALUSrcB     = reset ? 2'd0 : ctrl_q.alu_src_b;
  assign ALUOp       = reset ? '0 : aluop_ext;
  assign PCSource    = reset ? 2'd0 : ctrl_q.pc_source;
  assign IllegalOp   = ~reset & illegal_q;
  assign State       = reset ? '0 : state_ext;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected control vectors via a scoreboard queue.
`timescale 1ns/1ps
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OP = 6'h00;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] RegDst;
  logic       RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       IllegalOp;
  logic [3:0] State;

  multicycle_control #(.ALUOP_WIDTH(3), .STATE_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r;
    logic [1:0] rdst;
    logic       rw, asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic [1:0] pcs;
    logic       ill;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic       mr;
    int         st;
    logic       ill;
  } row_t;

  out_t sb_q[$];
  int   vectors = 0;
  int   fails = 0;

  function automatic out_t observe();
    out_t o;
    o.st = State; o.pcw = PCWrite; o.pcwc = PCWriteCond; o.iord = IorD;
    o.mrd = MemRead; o.mwr = MemWrite; o.irw = IRWrite; o.m2r = MemtoReg;
    o.rdst = RegDst; o.rw = RegWrite; o.asa = ALUSrcA; o.asb = ALUSrcB;
    o.aop = ALUOp; o.pcs = PCSource; o.ill = IllegalOp;
    return o;
  endfunction

  // Reference outputs per state, written from the state table of the control unit.
  function automatic out_t model(int st, logic [5:0] op, logic z, logic mr, logic ill);
    out_t o;
    o = '0;
    o.st = st[3:0];
    o.ill = ill;
    case (st)
      0:  begin o.mrd = 1; o.asb = 2'd1; o.irw = mr; o.pcw = mr; end
      1:  o.asb = 2'd3;
      2:  begin o.asa = 1; o.asb = 2'd2; end
      3:  begin o.mrd = 1; o.iord = 1; end
      4:  begin o.rw = 1; o.m2r = 1; end
      5:  begin o.mwr = 1; o.iord = 1; end
      6:  begin o.asa = 1; o.aop = 3'b010; end
      7:  begin o.rdst = 2'd1; o.rw = 1; end
      8:  begin o.asa = 1; o.aop = 3'b001; o.pcs = 2'd1; o.pcwc = (op == 6'h04) ? z : ~z; end
      9:  begin
        o.asa = 1; o.asb = 2'd2;
        case (op)
          6'h08:   o.aop = 3'b100;
          6'h0C:   o.aop = 3'b110;
          6'h0D:   o.aop = 3'b101;
          default: o.aop = 3'b111;
        endcase
      end
      10: o.rw = 1;
      11: begin
        o.pcw = 1; o.pcs = 2'd2;
        if (op == 6'h03) begin o.rw = 1; o.rdst = 2'd2; end
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic test_reset();
    out_t exp, obs;
    @(negedge clk);
    sb_q.push_back('0);
    #1;
    exp = sb_q.pop_front(); obs = observe(); vectors++;
    if (obs !== exp) begin fails++; $display("FAIL reset_hold: got %h want %h", obs, exp); end
    @(negedge clk);
    reset = 1'b0; MemReady = 1'b0;
    sb_q.push_back(model(0, 6'h00, 1'b0, 1'b0, 1'b0));
    #1;
    exp = sb_q.pop_front(); obs = observe(); vectors++;
    if (obs !== exp) begin fails++; $display("FAIL reset_release: got %h want %h", obs, exp); end
    @(negedge clk);
  endtask

  task automatic test_rtype();
    row_t rows[$];
    out_t exp, obs;
    rows.push_back('{6'h00, 1'b0, 1'b1, 0, 1'b0});
    rows.push_back('{6'h00, 1'b0, 1'b1, 1, 1'b0});
    rows.push_back('{6'h00, 1'b0, 1'b1, 6, 1'b0});
    rows.push_back('{6'h00, 1'b0, 1'b1, 7, 1'b0});
    foreach (rows[i]) begin
      OP = rows[i].op; Zero = rows[i].z; MemReady = rows[i].mr;
      sb_q.push_back(model(rows[i].st, rows[i].op, rows[i].z, rows[i].mr, rows[i].ill));
      #1;
      exp = sb_q.pop_front(); obs = observe(); vectors++;
      if (obs !== exp) begin fails++; $display("FAIL rtype row%0d: got %h want %h", i, obs, exp); end
      @(negedge clk);
    end
  endtask

  // LW with a 3-cycle memory stall; OP is changed after DECODE and must be ignored.
  task automatic test_lw_wait();
    row_t rows[$];
    out_t exp, obs;
    rows.push_back('{6'h23, 1'b0, 1'b1, 0, 1'b0});
    rows.push_back('{6'h23, 1'b0, 1'b0, 1, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b0, 2, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b0, 3, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b0, 3, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b0, 3, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b1, 3, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b0, 4, 1'b0});
    foreach (rows[i]) begin
      OP = rows[i].op; Zero = rows[i].z; MemReady = rows[i].mr;
      sb_q.push_back(model(rows[i].st, rows[i].op, rows[i].z, rows[i].mr, rows[i].ill));
      #1;
      exp = sb_q.pop_front(); obs = observe(); vectors++;
      if (obs !== exp) begin fails++; $display("FAIL lw_wait row%0d: got %h want %h", i, obs, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    row_t rows[$];
    out_t exp, obs;
    rows.push_back('{6'h2B, 1'b0, 1'b1, 0, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b1, 1, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b0, 2, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b0, 5, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b1, 5, 1'b0});
    foreach (rows[i]) begin
      OP = rows[i].op; Zero = rows[i].z; MemReady = rows[i].mr;
      sb_q.push_back(model(rows[i].st, rows[i].op, rows[i].z, rows[i].mr, rows[i].ill));
      #1;
      exp = sb_q.pop_front(); obs = observe(); vectors++;
      if (obs !== exp) begin fails++; $display("FAIL sw row%0d: got %h want %h", i, obs, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_memwr();
    row_t rows[$];
    out_t exp, obs;
    rows.push_back('{6'h2B, 1'b0, 1'b1, 0, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b1, 1, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b0, 2, 1'b0});
    rows.push_back('{6'h2B, 1'b0, 1'b0, 5, 1'b0});
    foreach (rows[i]) begin
      OP = rows[i].op; Zero = rows[i].z; MemReady = rows[i].mr;
      sb_q.push_back(model(rows[i].st, rows[i].op, rows[i].z, rows[i].mr, rows[i].ill));
      #1;
      exp = sb_q.pop_front(); obs = observe(); vectors++;
      if (obs !== exp) begin fails++; $display("FAIL midrst row%0d: got %h want %h", i, obs, exp); end
      @(negedge clk);
    end
    reset = 1'b1;
    sb_q.push_back('0);
    #1;
    exp = sb_q.pop_front(); obs = observe(); vectors++;
    if (obs !== exp) begin fails++; $display("FAIL midrst_assert: got %h want %h", obs, exp); end
    @(posedge clk);
    sb_q.push_back('0);
    #1;
    exp = sb_q.pop_front(); obs = observe(); vectors++;
    if (obs !== exp) begin fails++; $display("FAIL midrst_held: got %h want %h", obs, exp); end
    @(negedge clk);
    reset = 1'b0; MemReady = 1'b0;
    sb_q.push_back(model(0, 6'h2B, 1'b0, 1'b0, 1'b0));
    #1;
    exp = sb_q.pop_front(); obs = observe(); vectors++;
    if (obs !== exp) begin fails++; $display("FAIL midrst_release: got %h want %h", obs, exp); end
    @(negedge clk);
  endtask

  task automatic test_branch();
    row_t rows[$];
    out_t exp, obs;
    logic [5:0] ops[4] = '{6'h04, 6'h05, 6'h05, 6'h04};
    logic       zs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      rows.push_back('{ops[k], zs[k], 1'b1, 0, 1'b0});
      rows.push_back('{ops[k], zs[k], 1'b1, 1, 1'b0});
      rows.push_back('{ops[k], zs[k], 1'b1, 8, 1'b0});
    end
    foreach (rows[i]) begin
      OP = rows[i].op; Zero = rows[i].z; MemReady = rows[i].mr;
      sb_q.push_back(model(rows[i].st, rows[i].op, rows[i].z, rows[i].mr, rows[i].ill));
      #1;
      exp = sb_q.pop_front(); obs = observe(); vectors++;
      if (obs !== exp) begin fails++; $display("FAIL branch row%0d: got %h want %h", i, obs, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_itype();
    row_t rows[$];
    out_t exp, obs;
    logic [5:0] ops[4] = '{6'h0F, 6'h08, 6'h0C, 6'h0D};
    for (int k = 0; k < 4; k++) begin
      rows.push_back('{ops[k], 1'b0, 1'b1, 0, 1'b0});
      rows.push_back('{ops[k], 1'b0, 1'b1, 1, 1'b0});
      rows.push_back('{ops[k], 1'b0, 1'b1, 9, 1'b0});
      rows.push_back('{ops[k], 1'b0, 1'b1, 10, 1'b0});
    end
    foreach (rows[i]) begin
      OP = rows[i].op; Zero = rows[i].z; MemReady = rows[i].mr;
      sb_q.push_back(model(rows[i].st, rows[i].op, rows[i].z, rows[i].mr, rows[i].ill));
      #1;
      exp = sb_q.pop_front(); obs = observe(); vectors++;
      if (obs !== exp) begin fails++; $display("FAIL itype row%0d: got %h want %h", i, obs, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    row_t rows[$];
    out_t exp, obs;
    rows.push_back('{6'h3F, 1'b0, 1'b1, 0, 1'b0});
    rows.push_back('{6'h3F, 1'b0, 1'b0, 1, 1'b0});
    rows.push_back('{6'h3F, 1'b0, 1'b0, 0, 1'b1});
    rows.push_back('{6'h3F, 1'b0, 1'b0, 0, 1'b0});
    foreach (rows[i]) begin
      OP = rows[i].op; Zero = rows[i].z; MemReady = rows[i].mr;
      sb_q.push_back(model(rows[i].st, rows[i].op, rows[i].z, rows[i].mr, rows[i].ill));
      #1;
      exp = sb_q.pop_front(); obs = observe(); vectors++;
      if (obs !== exp) begin fails++; $display("FAIL illegal row%0d: got %h want %h", i, obs, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_jump();
    row_t rows[$];
    out_t exp, obs;
    logic [5:0] ops[2] = '{6'h03, 6'h02};
    for (int k = 0; k < 2; k++) begin
      rows.push_back('{ops[k], 1'b0, 1'b1, 0, 1'b0});
`ifdef MULTICYCLE_JUMP_EN
      rows.push_back('{ops[k], 1'b0, 1'b0, 1, 1'b0});
      rows.push_back('{ops[k], 1'b0, 1'b0, 11, 1'b0});
`else
      rows.push_back('{ops[k], 1'b0, 1'b0, 1, 1'b0});
      rows.push_back('{ops[k], 1'b0, 1'b0, 0, 1'b1});
      rows.push_back('{ops[k], 1'b0, 1'b0, 0, 1'b0});
`endif
    end
    foreach (rows[i]) begin
      OP = rows[i].op; Zero = rows[i].z; MemReady = rows[i].mr;
      sb_q.push_back(model(rows[i].st, rows[i].op, rows[i].z, rows[i].mr, rows[i].ill));
      #1;
      exp = sb_q.pop_front(); obs = observe(); vectors++;
      if (obs !== exp) begin fails++; $display("FAIL jump row%0d: got %h want %h", i, obs, exp); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_reset_mid_memwr();
    test_branch();
    test_itype();
    test_illegal();
    test_jump();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
